// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: FSM encoding,
// default reset vector, return-address offset and alignment mask helper.
package pc_gen_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [63:0] RESET_VEC_DFLT = 64'h8000_0000;

  // Calls are always treated as 4-byte instructions, even when ALIGN = 2.
  localparam int unsigned RET_OFS = 4;

  function automatic logic [63:0] align_mask(input int unsigned align);
    return 64'(align - 1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pop-then-push on one op, overwrite-oldest
// when full, synchronous clear. Only built when PC_GEN_RAS_EN is defined.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_push_addr,
  output logic [XLEN-1:0] o_top_c,
  output logic            o_nonempty_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_cnt;

  logic            w_pop_ok;
  logic [PW-1:0]   w_top_p;
  logic [PW-1:0]   w_top_n;
  logic [CW-1:0]   w_cnt_p;
  logic [CW-1:0]   w_cnt_n;

  // Pop is applied first so a combined call/return replaces the top entry.
  always_comb begin
    w_pop_ok = i_pop && (r_cnt != '0);
    w_top_p  = w_pop_ok ? r_top - PW'(1) : r_top;
    w_cnt_p  = i_clr ? '0 : (w_pop_ok ? r_cnt - CW'(1) : r_cnt);
    w_top_n  = i_push ? w_top_p + PW'(1) : w_top_p;
    w_cnt_n  = (i_push && (w_cnt_p != CW'(DEPTH))) ? w_cnt_p + CW'(1) : w_cnt_p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top <= '0;
      r_cnt <= '0;
    end else begin
      r_top <= w_top_n;
      r_cnt <= w_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_top_n] <= i_push_addr;
  end

  assign o_top_c      = r_mem[r_top];
  assign o_nonempty_c = (r_cnt != '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with trap/jump/RAS/predicted-PC
// priority and misalignment parking. Optional RAS enabled by PC_GEN_RAS_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter logic [63:0] RESET_VEC = RESET_VEC_DFLT,
  parameter int unsigned ALIGN     = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic            fetch_o_valid,
  input  logic            fetch_i_ready,
  input  logic [XLEN-1:0] fetch_i_pre_pc,
  input  logic            fetch_i_is_call,
  input  logic            fetch_i_is_ret,
  input  logic            execute_i_is_jump,
  input  logic [XLEN-1:0] execute_i_pre_pc,
  input  logic            trap_i_valid,
  input  logic [XLEN-1:0] trap_i_vec,
  output logic            pc_o_misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(ALIGN));
  localparam logic [XLEN-1:0] RET_INC    = XLEN'(RET_OFS);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_misalign;

  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_valid_nxt;
  logic            w_misalign_nxt;
  logic            w_load;
  logic [XLEN-1:0] w_target;
  logic            w_fire;
  logic            w_ras_hit;
  logic [XLEN-1:0] w_ras_top;

  assign w_fire = r_valid & fetch_i_ready;

`ifdef PC_GEN_RAS_EN
  logic w_ras_nonempty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (trap_i_valid && (r_state != ST_BOOT)),
    .i_push       (w_fire & fetch_i_is_call),
    .i_pop        (w_fire & fetch_i_is_ret),
    .i_push_addr  (r_pc + RET_INC),
    .o_top_c      (w_ras_top),
    .o_nonempty_c (w_ras_nonempty)
  );

  assign w_ras_hit = w_fire & fetch_i_is_ret & w_ras_nonempty;
`else
  logic w_unused;

  assign w_ras_hit = 1'b0;
  assign w_ras_top = '0;
  assign w_unused  = ^{fetch_i_is_call, fetch_i_is_ret, 1'(RAS_DEPTH), RET_INC};
`endif

  // Target selection and state transition; a misaligned load parks in FAULT.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_valid;
    w_misalign_nxt = r_misalign;
    w_load         = 1'b0;
    w_target       = r_pc;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
        w_valid_nxt = 1'b1;
      end
      ST_RUN: begin
        if (trap_i_valid) begin
          w_load   = 1'b1;
          w_target = trap_i_vec;
        end else if (execute_i_is_jump) begin
          w_load   = 1'b1;
          w_target = execute_i_pre_pc;
        end else if (w_ras_hit) begin
          w_load   = 1'b1;
          w_target = w_ras_top;
        end else if (w_fire) begin
          w_load   = 1'b1;
          w_target = fetch_i_pre_pc;
        end
      end
      ST_FAULT: begin
        if (trap_i_valid) begin
          w_load   = 1'b1;
          w_target = trap_i_vec;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_valid_nxt = 1'b0;
      end
    endcase

    if (w_load) begin
      w_pc_nxt = w_target;
      if ((w_target & ALIGN_MASK) != '0) begin
        w_state_nxt    = ST_FAULT;
        w_valid_nxt    = 1'b0;
        w_misalign_nxt = 1'b1;
      end else begin
        w_state_nxt    = ST_RUN;
        w_valid_nxt    = 1'b1;
        w_misalign_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= XLEN'(RESET_VEC);
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign fetch_o_pc    = r_pc;
  assign fetch_o_valid = r_valid;
  assign pc_o_misalign = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares. RAS cases run when PC_GEN_RAS_EN is set.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] fetch_o_pc;
  logic        fetch_o_valid;
  logic        fetch_i_ready = 1'b0;
  logic [63:0] fetch_i_pre_pc = '0;
  logic        fetch_i_is_call = 1'b0;
  logic        fetch_i_is_ret = 1'b0;
  logic        execute_i_is_jump = 1'b0;
  logic [63:0] execute_i_pre_pc = '0;
  logic        trap_i_valid = 1'b0;
  logic [63:0] trap_i_vec = '0;
  logic        pc_o_misalign;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN      (64),
    .RESET_VEC (64'h8000_0000),
    .ALIGN     (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_o_pc        (fetch_o_pc),
    .fetch_o_valid     (fetch_o_valid),
    .fetch_i_ready     (fetch_i_ready),
    .fetch_i_pre_pc    (fetch_i_pre_pc),
    .fetch_i_is_call   (fetch_i_is_call),
    .fetch_i_is_ret    (fetch_i_is_ret),
    .execute_i_is_jump (execute_i_is_jump),
    .execute_i_pre_pc  (execute_i_pre_pc),
    .trap_i_valid      (trap_i_valid),
    .trap_i_vec        (trap_i_vec),
    .pc_o_misalign     (pc_o_misalign)
  );

  typedef struct {
    string       nm;
    logic [63:0] pc;
    logic        v;
    logic        m;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] epc, input logic ev, input logic em);
    total++;
    if (fetch_o_pc !== epc || fetch_o_valid !== ev || pc_o_misalign !== em) begin
      bad++;
      $display("FAIL %s: got pc=%h valid=%b misalign=%b, want pc=%h valid=%b misalign=%b",
               nm, fetch_o_pc, fetch_o_valid, pc_o_misalign, epc, ev, em);
    end
  endtask

  // Monitor: one expectation per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.nm, e.pc, e.v, e.m);
    end
  end

  // Apply inputs for one edge, then queue the outputs expected after it.
  task automatic drive(input string nm, input logic rdy, input logic [63:0] pre,
                       input logic call, input logic ret,
                       input logic jmp, input logic [63:0] epc,
                       input logic trp, input logic [63:0] tv,
                       input logic [63:0] xpc, input logic xv, input logic xm);
    exp_t e;
    fetch_i_ready     = rdy;
    fetch_i_pre_pc    = pre;
    fetch_i_is_call   = call;
    fetch_i_is_ret    = ret;
    execute_i_is_jump = jmp;
    execute_i_pre_pc  = epc;
    trap_i_valid      = trp;
    trap_i_vec        = tv;
    @(posedge clk);
    #1;
    e.nm = nm; e.pc = xpc; e.v = xv; e.m = xm;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 64'h8000_0000, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("boot_c0", 64'h8000_0000, 1'b0, 1'b0);

    drive("boot_c1", 0, 64'h0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0000, 1, 0);
    drive("seq_4",   1, 64'h8000_0004, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0004, 1, 0);
    drive("seq_8",   1, 64'h8000_0008, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0008, 1, 0);
    drive("seq_c",   1, 64'h8000_000C, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_000C, 1, 0);
    drive("seq_10",  1, 64'h8000_0010, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0010, 1, 0);
    for (int i = 0; i < 3; i++)
      drive("stall", 0, 64'hDEAD_0000, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0010, 1, 0);
    drive("stall_jump", 0, 64'hDEAD_0000, 0, 0, 1, 64'h8000_0100, 0, 64'h0, 64'h8000_0100, 1, 0);
    drive("after_jump", 1, 64'h8000_0104, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0104, 1, 0);
    drive("trap_vs_jump", 1, 64'h8000_0108, 0, 0, 1, 64'h8000_0300, 1, 64'h8000_0200,
          64'h8000_0200, 1, 0);
    drive("misalign_jump", 1, 64'h8000_0204, 0, 0, 1, 64'h8000_0102, 0, 64'h0,
          64'h8000_0102, 0, 1);
    drive("fault_ignores_jump", 1, 64'h8000_0104, 0, 0, 1, 64'h8000_0300, 0, 64'h0,
          64'h8000_0102, 0, 1);
    drive("fault_trap_exit", 0, 64'h0, 0, 0, 0, 64'h0, 1, 64'h8000_0400,
          64'h8000_0400, 1, 0);
    drive("misalign_pre_pc", 1, 64'h8000_0402, 0, 0, 0, 64'h0, 0, 64'h0,
          64'h8000_0402, 0, 1);
    drive("fault_trap_misaligned", 0, 64'h0, 0, 0, 0, 64'h0, 1, 64'h8000_0501,
          64'h8000_0501, 0, 1);
    drive("fault_trap_ok", 0, 64'h0, 0, 0, 0, 64'h0, 1, 64'h8000_0500,
          64'h8000_0500, 1, 0);

`ifdef PC_GEN_RAS_EN
    drive("ras_trap_a", 0, 64'h0, 0, 0, 0, 64'h0, 1, 64'h8000_1000, 64'h8000_1000, 1, 0);
    drive("call_a", 1, 64'h8000_2000, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_2000, 1, 0);
    drive("call_b", 1, 64'h8000_3000, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_3000, 1, 0);
    drive("call_c", 1, 64'h8000_4000, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_4000, 1, 0);
    drive("call_d", 1, 64'h8000_5000, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_5000, 1, 0);
    drive("call_e", 1, 64'h8000_6000, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_6000, 1, 0);
    drive("ret_1", 1, 64'h9990_0000, 0, 1, 0, 64'h0, 0, 64'h0, 64'h8000_5004, 1, 0);
    drive("ret_2", 1, 64'h9990_0000, 0, 1, 0, 64'h0, 0, 64'h0, 64'h8000_4004, 1, 0);
    drive("ret_3", 1, 64'h9990_0000, 0, 1, 0, 64'h0, 0, 64'h0, 64'h8000_3004, 1, 0);
    drive("ret_4", 1, 64'h9990_0000, 0, 1, 0, 64'h0, 0, 64'h0, 64'h8000_2004, 1, 0);
    drive("ret_5_empty", 1, 64'h8000_7000, 0, 1, 0, 64'h0, 0, 64'h0, 64'h8000_7000, 1, 0);
    drive("wrap_trap", 0, 64'h0, 0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC,
          64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
    drive("wrap_call", 1, 64'h8000_8000, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_8000, 1, 0);
    drive("wrap_ret", 1, 64'h1234_0000, 0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1, 0);
`else
    drive("ret_ignored", 1, 64'h8000_0504, 1, 1, 0, 64'h0, 0, 64'h0, 64'h8000_0504, 1, 0);
`endif

    drive("pre_reset_jump", 0, 64'h0, 0, 0, 1, 64'h8000_0600, 0, 64'h0, 64'h8000_0600, 1, 0);
    fetch_i_ready     = 1'b0;
    execute_i_is_jump = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", 64'h8000_0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 64'h8000_0000, 1'b0, 1'b0);
    rst = 1'b0;
    drive("reboot_c1", 0, 64'h0, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0000, 1, 0);
    drive("reboot_seq", 1, 64'h8000_0004, 0, 0, 0, 64'h0, 0, 64'h0, 64'h8000_0004, 1, 0);
    fetch_i_ready = 1'b0;

    w = 0;
    while (q.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
